// File: rtl/step_monitor_pkg.sv
// ----------------------------------------------------------------------------
// step_monitor_pkg
// Shared constants for the step/dir monitor: register byte offsets, STATUS and
// CTRL bit positions, the default position width, and a helper that turns a
// byte offset into the 2-bit word select used by the APB decoder.
// ----------------------------------------------------------------------------
package step_monitor_pkg;

    localparam int POS_W_DEFAULT = 16;

    // Register byte offsets (only bits [3:2] are decoded).
    localparam logic [3:0] ADDR_POS1   = 4'h0;
    localparam logic [3:0] ADDR_POS2   = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    // STATUS bits
    localparam int STAT_GLITCH1 = 0;
    localparam int STAT_GLITCH2 = 1;
    localparam int STAT_HI1     = 2;
    localparam int STAT_HI2     = 3;

    // CTRL bits
    localparam int CTRL_EN1    = 0;
    localparam int CTRL_EN2    = 1;
    localparam int CTRL_IRQ_EN = 2;

    function automatic logic [1:0] word_sel(input logic [3:0] offset);
        return offset[3:2];
    endfunction

endpackage

// File: rtl/step_monitor_axis.sv
// ----------------------------------------------------------------------------
// step_axis_decoder
// Decodes one axis' step/dir pin pair into a signed position counter.
//   clk, rst        : clock, asynchronous active-high reset
//   step_i, dir_i   : asynchronous pin taps
//   en_i            : axis enable (0 holds the high-run counter at 0)
//   load_i          : load pos from load_val_i this cycle (wins over a step)
//   load_val_i      : value to load
//   pos_o           : position counter (two's complement, wraps)
//   step_hi_o       : synchronized step level
//   glitch_o        : one-cycle pulse when a too-short high pulse ends
// ----------------------------------------------------------------------------
module step_axis_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 8,
    parameter int POS_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_i,
    input  logic             dir_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [POS_W-1:0] load_val_i,
    output logic [POS_W-1:0] pos_o,
    output logic             step_hi_o,
    output logic             glitch_o
);

    localparam logic [7:0] MIN_CNT = 8'(MIN_PULSE);

    logic [SYNC_STAGES-1:0] step_sync_q;
    logic [SYNC_STAGES-1:0] dir_sync_q;
    logic [7:0]             hcnt_q, hcnt_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic                   step_s, dir_s;
    logic                   count_evt;
    logic                   glitch_evt;

    assign step_s = step_sync_q[SYNC_STAGES-1];
    assign dir_s  = dir_sync_q[SYNC_STAGES-1];

    // Synchronizers keep running even when the axis is disabled so that the
    // STATUS hi bit always reflects the pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_sync_q <= '0;
            dir_sync_q  <= '0;
        end else begin
            step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step_i};
            dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], dir_i};
        end
    end

    // hcnt saturates at MIN_CNT, so the MIN_CNT-1 -> MIN_CNT transition
    // happens exactly once per high pulse no matter how long it lasts.
    always_comb begin
        hcnt_d     = hcnt_q;
        count_evt  = 1'b0;
        glitch_evt = 1'b0;
        if (!en_i) begin
            hcnt_d = '0;
        end else if (step_s) begin
            if (hcnt_q != MIN_CNT) begin
                hcnt_d = hcnt_q + 8'd1;
            end
            count_evt = (hcnt_q == MIN_CNT - 8'd1);
        end else begin
            hcnt_d     = '0;
            glitch_evt = (hcnt_q != 8'd0) && (hcnt_q != MIN_CNT);
        end
    end

    // A firmware load on the same edge as a count event discards the step.
    always_comb begin
        pos_d = pos_q;
        if (load_i) begin
            pos_d = load_val_i;
        end else if (count_evt) begin
            pos_d = dir_s ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            pos_q  <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            pos_q  <= pos_d;
        end
    end

    assign pos_o     = pos_q;
    assign step_hi_o = step_s;
    assign glitch_o  = glitch_evt;

endmodule

// File: rtl/step_monitor.sv
// ----------------------------------------------------------------------------
// step_monitor
// Two-axis step/dir monitor with an APB3 slave for firmware read-back.
//   PCLK, PRESET        : clock, asynchronous active-high reset
//   PSEL..PWDATA        : APB3 request (only PADDR[3:2] decoded)
//   PRDATA              : registered read data (loaded in the setup phase)
//   PREADY, PSLVERR     : constant 1 / 0 (zero wait states, no errors)
//   step1/dir1, step2/dir2 : asynchronous pin taps of the stepper drivers
//   irq                 : registered irq_en & (glitch1 | glitch2)
// Registers: POS1 (0x0), POS2 (0x4), STATUS (0x8), CTRL (0xC).
// ----------------------------------------------------------------------------
module step_monitor
    import step_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 8,
    parameter int POS_W       = POS_W_DEFAULT
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        step1,
    input  logic        dir1,
    input  logic        step2,
    input  logic        dir2,
    output logic        irq
);

    logic             apb_wr;
    logic             apb_rd;
    logic [1:0]       reg_sel;
    logic [1:0]       axis_step;
    logic [1:0]       axis_dir;
    logic [1:0]       axis_hi;
    logic [1:0]       axis_glitch;
    logic [1:0]       pos_load;
    logic [POS_W-1:0] pos [2];

    logic [2:0]       ctrl_q, ctrl_d;
    logic [1:0]       glitch_q, glitch_d;
    logic             irq_q, irq_d;
    logic [31:0]      prdata_q, prdata_d;
    logic [31:0]      rdata_mux;

    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign apb_rd    = PSEL & ~PENABLE & ~PWRITE;
    assign reg_sel   = PADDR[3:2];
    assign axis_step = {step2, step1};
    assign axis_dir  = {dir2, dir1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            assign pos_load[gi] = apb_wr &&
                (reg_sel == word_sel((gi == 0) ? ADDR_POS1 : ADDR_POS2));

            step_axis_decoder #(
                .SYNC_STAGES (SYNC_STAGES),
                .MIN_PULSE   (MIN_PULSE),
                .POS_W       (POS_W)
            ) u_axis (
                .clk        (PCLK),
                .rst        (PRESET),
                .step_i     (axis_step[gi]),
                .dir_i      (axis_dir[gi]),
                .en_i       (ctrl_q[CTRL_EN1 + gi]),
                .load_i     (pos_load[gi]),
                .load_val_i (PWDATA[POS_W-1:0]),
                .pos_o      (pos[gi]),
                .step_hi_o  (axis_hi[gi]),
                .glitch_o   (axis_glitch[gi])
            );
        end
    endgenerate

    // Sticky flags: a new glitch in the same cycle as a W1C keeps the flag set.
    always_comb begin
        glitch_d = glitch_q;
        ctrl_d   = ctrl_q;
        if (apb_wr && reg_sel == word_sel(ADDR_STATUS)) begin
            glitch_d = glitch_q & ~PWDATA[STAT_GLITCH2:STAT_GLITCH1];
        end
        glitch_d = glitch_d | axis_glitch;
        if (apb_wr && reg_sel == word_sel(ADDR_CTRL)) begin
            ctrl_d = PWDATA[2:0];
        end
    end

    // irq follows the registered flags, so it lags a new flag by one cycle.
    assign irq_d = ctrl_q[CTRL_IRQ_EN] & (|glitch_q);

    always_comb begin
        rdata_mux = '0;
        case (reg_sel)
            word_sel(ADDR_POS1): rdata_mux = 32'(signed'(pos[0]));
            word_sel(ADDR_POS2): rdata_mux = 32'(signed'(pos[1]));
            word_sel(ADDR_STATUS): begin
                rdata_mux[STAT_GLITCH1] = glitch_q[0];
                rdata_mux[STAT_GLITCH2] = glitch_q[1];
                rdata_mux[STAT_HI1]     = axis_hi[0];
                rdata_mux[STAT_HI2]     = axis_hi[1];
            end
            default: rdata_mux[2:0] = ctrl_q;
        endcase
    end

    // PRDATA is captured in the setup phase and held through the access phase.
    assign prdata_d = apb_rd ? rdata_mux : prdata_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_q   <= '0;
            glitch_q <= '0;
            irq_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            glitch_q <= glitch_d;
            irq_q    <= irq_d;
            prdata_q <= prdata_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign irq     = irq_q;

    // Address and data bits outside the decoded fields are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:POS_W]};

endmodule
